mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the five-stage MIPS pipeline. Consumes the EX/MEM latch outputs, issues at most one data-memory request per instruction, stalls the pipeline until `dhit`, selects the write-back value and registers it for the WB stage. Also tracks halt and freezes the stage once a halt has committed.

## Interface
Parameters:
- none; widths come from `cpu_types_pkg` (`word_t` = 32 bits, `regbits_t` = 5 bits).

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `ex_valid`  in  1  EX/MEM latch holds a real instruction (0 = bubble).
- `dREN_in`, `dWEN_in`  in  1 each  load / store request from EX/MEM.
- `daddr_in`  in  32  ALU result (portO); memory address, or the ALU write-back value.
- `dstore_in`  in  32  store data.
- `regWr_in`  in  1  register write enable.
- `wsel_in`  in  5  destination register.
- `memToReg_in`  in  2  write-back select: 00 ALU, 01 load data, 10 LUI value, 11 pc4 (JAL).
- `luiValue_in`, `pc4_in`  in  32 each  alternate write-back sources.
- `halt_in`  in  1  instruction is HALT.
- `stall_ext`  in  1  stall from elsewhere in the pipeline, e.g. an ihit miss.
- `dhit`  in  1  data cache completes the current request this cycle.
- `dmemload`  in  32  load data, valid when `dhit`=1.
- `dmemREN`, `dmemWEN`  out  1 each  data-memory request.
- `dmemaddr`, `dmemstore`  out  32 each  request address and data.
- `mem_stall`  out  1  holds PC and all upstream latches.
- `wb_valid`, `wb_regWr`, `wb_halt`  out  1 each  registered WB control.
- `wb_wsel`  out  5  registered destination.
- `wb_wdat`  out  32  registered write-back data.

## Operation
- States: IDLE, DONE, HALTED. On reset: state IDLE; all `wb_*` outputs and the load buffer are 0.
- `req` = `ex_valid` & (`dREN_in` | `dWEN_in`) & (state==IDLE).
- `dmemWEN` = `req` & `dWEN_in`.
- `dmemREN` = `req` & `dREN_in` & !`dWEN_in`. When both enables are set, the store wins.
- `dmemaddr` = `daddr_in` and `dmemstore` = `dstore_in` (unmodified, low bits included). When `req`=0, all four request outputs are 0.
- `mem_stall` = `req` & !`dhit`.
- `advance` = !`mem_stall` & !`stall_ext` & (state!=HALTED).
- State transitions:
  - IDLE → DONE: `req` & `dhit` & `stall_ext`. The load data goes into the buffer and the request drops, so the access is never reissued.
  - DONE → IDLE: on `advance`.
  - Any state → HALTED: `advance` & `ex_valid` & `halt_in`.
  - HALTED is left only by reset.
- Write-back data:
  - Load source = `dmemload` in IDLE, the buffer in DONE.
  - `wb_wdat` is muxed from `memToReg_in` and is full 32 bits with no extension.
- On `advance`, WB loads:
  - `wb_valid`←`ex_valid`
  - `wb_regWr`←`ex_valid`&`regWr_in`
  - `wb_wsel`, `wb_wdat`, and `wb_halt`←`ex_valid`&`halt_in`.
- On no `advance`, WB loads a bubble: `wb_valid`=`wb_regWr`=0. `wb_wsel`/`wb_wdat` are don't-care and hold. `wb_halt` keeps its value.
- In HALTED: no requests, `mem_stall`=0, `wb_halt`=1, `wb_valid`=0.
- Reset mid-request: all outputs go to their reset values immediately (asynchronous), and any pending access is abandoned.

## Timing
- Non-memory instruction: zero added latency. The WB register is updated on the edge ending the cycle it is presented, if `stall_ext`=0.
- Load/store: the request is combinational in the same cycle the instruction is presented. It is held until `dhit`; WB is captured on the `dhit` edge when `stall_ext`=0.
- Total memory-stage cycles = cycles up to and including `dhit` (1 if the cache hits immediately).
- `dhit` without `req` is ignored.
- `stall_ext` and `dhit` in the same cycle: the access completes, and the data is buffered (DONE).

## Structure
- `cpu_types_pkg` holds:
  - `word_t` and `regbits_t`.
  - A `memtoreg_t` enum: MTR_ALU, MTR_MEM, MTR_LUI, MTR_PC4.
  - A `memstate_t` enum: IDLE, DONE, HALTED.
- New interface `mem_wb_if` carries the `wb_*` signals, with modports for the stage, writeback and tb.
- Single module; no sub-module is warranted. The mux and FSM stay inline.

## Test plan
- ALU op: `ex_valid`=1, `memToReg`=00, `daddr_in`=0x0000_0010, `wsel`=5, `regWr`=1 → next edge `wb_wdat`=0x10, `wb_wsel`=5, `wb_regWr`=1, `mem_stall` never 1.
- Load, `dhit` on the 3rd cycle, `dmemload`=0xDEAD_BEEF, `daddr_in`=0x100:
  - `dmemREN`=1 and `dmemaddr`=0x100 for 3 cycles.
  - `mem_stall`=1 for 2 cycles.
  - `wb_wdat`=0xDEAD_BEEF after edge 3.
  - Bubbles (`wb_valid`=0) before that.
- Store with `dhit` while `stall_ext`=1 for 2 more cycles:
  - `dmemWEN` asserted exactly 1 cycle-burst, not reissued; state DONE.
  - WB captures the store (`wb_regWr`=0) when `stall_ext` falls.
- Load with `stall_ext` at `dhit`, `dmemload`=0x1234 then 0xFFFF → buffered 0x1234 reaches `wb_wdat`.
- HALT then a load behind it: `wb_halt`=1 is held, the following load never drives `dmemREN`, `mem_stall`=0.
- Assert `RST` mid-load: `dmemREN`, `mem_stall` and all `wb_*` go to 0 without a clock edge; state is IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath widths and the enums used by the memory/write-back stage.
// No logic; consumed by the stage and its write-back interface.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_LUI = 2'b10,
        MTR_PC4 = 2'b11
    } memtoreg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DONE   = 2'b01,
        HALTED = 2'b10
    } memstate_t;

endpackage

// File: rtl/mem_wb_if.sv
// MEM/WB pipeline register bundle: driven by the memory stage, read by write-back.
// Pure wiring, zero latency; no flow control of its own.
interface mem_wb_if;
    import cpu_types_pkg::*;

    logic     wb_valid;
    logic     wb_regWr;
    logic     wb_halt;
    regbits_t wb_wsel;
    word_t    wb_wdat;

    modport stage     (output wb_valid, wb_regWr, wb_halt, wb_wsel, wb_wdat);
    modport writeback (input  wb_valid, wb_regWr, wb_halt, wb_wsel, wb_wdat);
    modport tb        (input  wb_valid, wb_regWr, wb_halt, wb_wsel, wb_wdat);
endinterface

// File: rtl/mem_wb_stage.sv
// MIPS memory stage + MEM/WB register: one data request per instruction, stalls until dhit.
// Latency: WB captured on the dhit edge (or same edge for non-memory ops); holds on stall_ext.
module mem_wb_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    input  logic [31:0] daddr_in,
    input  logic [31:0] dstore_in,
    input  logic        regWr_in,
    input  logic [4:0]  wsel_in,
    input  logic [1:0]  memToReg_in,
    input  logic [31:0] luiValue_in,
    input  logic [31:0] pc4_in,
    input  logic        halt_in,
    input  logic        stall_ext,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_regWr,
    output logic        wb_halt,
    output logic [4:0]  wb_wsel,
    output logic [31:0] wb_wdat
);

    memstate_t state_q, state_d;
    word_t     buf_q, buf_d;

    logic      wb_valid_q, wb_valid_d;
    logic      wb_regWr_q, wb_regWr_d;
    logic      wb_halt_q,  wb_halt_d;
    regbits_t  wb_wsel_q,  wb_wsel_d;
    word_t     wb_wdat_q,  wb_wdat_d;

    logic      req;
    logic      stall_int;
    logic      advance;
    word_t     load_src;
    word_t     wdat_sel;

    // Internal request ignores RST so reset never feeds flop data paths;
    // the outputs below are gated so they drop immediately on reset.
    assign req       = ex_valid & (dREN_in | dWEN_in) & (state_q == IDLE);
    assign stall_int = req & ~dhit;
    assign advance   = ~stall_int & ~stall_ext & (state_q != HALTED);

    assign dmemWEN   = req & dWEN_in & ~RST;
    assign dmemREN   = req & dREN_in & ~dWEN_in & ~RST;
    assign dmemaddr  = (req & ~RST) ? daddr_in  : '0;
    assign dmemstore = (req & ~RST) ? dstore_in : '0;
    assign mem_stall = stall_int & ~RST;

    assign load_src = (state_q == DONE) ? buf_q : dmemload;

    always_comb begin
        wdat_sel = daddr_in;
        case (memtoreg_t'(memToReg_in))
            MTR_ALU: wdat_sel = daddr_in;
            MTR_MEM: wdat_sel = load_src;
            MTR_LUI: wdat_sel = luiValue_in;
            MTR_PC4: wdat_sel = pc4_in;
            default: wdat_sel = daddr_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                // Completed while the pipe is frozen: park the data so the access is not reissued.
                if (req & dhit & stall_ext) begin
                    state_d = DONE;
                    buf_d   = dmemload;
                end
            end
            DONE: begin
                if (advance) state_d = IDLE;
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
        if (advance & ex_valid & halt_in) state_d = HALTED;
    end

    always_comb begin
        wb_valid_d = advance & ex_valid;
        wb_regWr_d = advance & ex_valid & regWr_in;
        wb_wsel_d  = advance ? wsel_in  : wb_wsel_q;
        wb_wdat_d  = advance ? wdat_sel : wb_wdat_q;
        wb_halt_d  = advance ? (ex_valid & halt_in) : wb_halt_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_regWr_q <= 1'b0;
            wb_halt_q  <= 1'b0;
            wb_wsel_q  <= '0;
            wb_wdat_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            wb_valid_q <= wb_valid_d;
            wb_regWr_q <= wb_regWr_d;
            wb_halt_q  <= wb_halt_d;
            wb_wsel_q  <= wb_wsel_d;
            wb_wdat_q  <= wb_wdat_d;
        end
    end

    mem_wb_if wb_bus ();

    assign wb_bus.wb_valid = wb_valid_q;
    assign wb_bus.wb_regWr = wb_regWr_q;
    assign wb_bus.wb_halt  = wb_halt_q;
    assign wb_bus.wb_wsel  = wb_wsel_q;
    assign wb_bus.wb_wdat  = wb_wdat_q;

    assign wb_valid = wb_bus.wb_valid;
    assign wb_regWr = wb_bus.wb_regWr;
    assign wb_halt  = wb_bus.wb_halt;
    assign wb_wsel  = wb_bus.wb_wsel;
    assign wb_wdat  = wb_bus.wb_wdat;

endmodule
